fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the single write port of the byte FIFO between N producers (e.g. PS/2 RX bytes, host command bytes).
//  Round-robin arbitration, packet-atomic: a granted producer owns the port until its 'last' word is written.
//  Sits between the producers and the FIFO's wr/w_data/full pins. Never writes while full.
//  An idle-owner timeout frees the port from a stalled producer.
// PARAMETERS
//  B    8    data word width; must equal the FIFO word width
//  N    2    number of requesters, 2..8
//  IW   1    requester index width; IW >= clog2(N)
//  TW   8    timeout counter width
//  TMO  255  idle cycles in GRANT before forced release; 0 disables the timeout
// PORTS
//  clk         in   1      single clock; everything is posedge
//  reset_n     in   1      asynchronous, active-low reset
//  req         in   N      req[i]: producer i has a word on its data slice
//  last        in   N      last[i]: the current word of producer i ends its packet
//  data        in   N*B    producer words, flat; slice i = data[i*B +: B]
//  ack         out  N      ack[i]: word of producer i accepted this cycle (combinational)
//  fifo_full   in   1      FIFO full flag
//  fifo_wr     out  1      FIFO write strobe
//  fifo_w_data out  B      FIFO write data
//  grant_id    out  IW     current owner index; valid while busy=1
//  busy        out  1      1 in GRANT
//  timeout     out  1      one-cycle pulse on forced release
// BEHAVIOUR
//  Reset: state=IDLE, grant_id=0, rr_ptr=N-1, tmo_cnt=0, busy=0, timeout=0; ack=0 and fifo_wr=0 while reset_n=0.
//  Reset mid-packet: the grant is dropped and no write is issued. The producer must restart its packet.
//  IDLE:
//   - If any req: pick the first set req scanning from (rr_ptr+1) mod N upward, with wrap.
//   - grant_id <= winner, go to GRANT. One cycle of arbitration latency; nothing is written in IDLE.
//  GRANT (owner g):
//   - fifo_wr = ack[g] = req[g] & ~fifo_full. All other ack bits are 0.
//   - fifo_w_data = data slice g. It is also driven from slice g in IDLE, so it is don't-care but stable.
//   - Accepted word with last[g]=1: next state IDLE, rr_ptr <= g.
//     One IDLE bubble between packets, even when other reqs are pending.
//   - Accepted word with last[g]=0: stay in GRANT, tmo_cnt <= 0.
//   - req[g]=0 (packet gap): stay in GRANT, tmo_cnt increments.
//   - fifo_full=1 stall: tmo_cnt holds. Backpressure is not a timeout.
//   - TMO>0 and tmo_cnt reaches TMO-1 with req[g]=0:
//     next state IDLE, rr_ptr <= g, timeout=1 for one cycle, tmo_cnt <= 0.
//  Other requests never preempt an owner. req/data of non-owners are ignored.
//  fifo_wr is never 1 while fifo_full=1.
//   - This holds even when the consumer reads in the same cycle.
//   - The FIFO's simultaneous read+write path does not check full, so this guarantee is mandatory.
//  last[g] with req[g]=0 has no effect. Only accepted words count.
//  rr_ptr wrap: (N-1)+1 -> 0. N not a power of two: indices >= N are never granted.
//  Single-word packet: req=1 and last=1 is accepted in the first GRANT cycle.
// STRUCTURE
//  Shared package/header: state encoding (ST_IDLE=1'b0, ST_GRANT=1'b1).
//  Sub-module rr_pick:
//   - Combinational.
//   - Inputs: req[N], rr_ptr[IW]. Outputs: idx[IW], any.
//   - Implemented as a rotate, priority-encode, un-rotate.
//  The top level holds the state register, grant_id, rr_ptr, tmo_cnt, and the data/ack muxing.
// TESTING
//  Instantiate with the FIFO (B=8, W=2), N=2, TMO=4.
//  1. Reset: reset_n=0, req=2'b11 -> ack=0, fifo_wr=0, busy=0. Release: grant_id=0 after 1 cycle.
//  2. Fairness:
//     - req=2'b11 held, every word last=1.
//     - Expect grants 0,1,0,1 with an IDLE bubble between each.
//     - FIFO receives data0,data1,data0,data1.
//  3. Atomic packet:
//     - Producer 0 sends 0xA1,0xA2,0xA3 (last on 0xA3) while req[1]=1 throughout.
//     - FIFO holds A1,A2,A3 contiguously; producer 1 is granted only afterwards.
//  4. Full:
//     - Fill 4 words with no reads, then req[0]=1 -> fifo_wr=0, ack=0, busy stays 1, no timeout.
//     - One read -> the next word is written the following cycle.
//  5. Timeout:
//     - Owner 1 sends 0x55 (last=0) then drops req.
//     - After 4 idle cycles, timeout pulses once, busy=0, and the waiting producer 0 is granted next.
//  6. Mid-packet reset:
//     - Assert reset_n=0 between words 2 and 3 of a packet.
//     - fifo_wr=0 immediately; after release, state is IDLE and rr_ptr=N-1.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

  // Arbiter state: IDLE arbitrates, GRANT streams the owner's packet.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set req scanning upward from (rr_ptr+1) mod N.
// Built as rotate -> priority-encode -> un-rotate.
module fifo_wr_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [N-1:0] rot;
  int           start;
  int           off;

  // Rotate so the slot after rr_ptr sits at bit 0, take the lowest set bit, map back.
  always_comb begin
    start = (int'(rr_ptr_i) + 1) % N;
    rot   = '0;
    for (int k = 0; k < N; k++) begin
      rot[k] = req_i[(start + k) % N];
    end
    off = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    idx_o = IW'((start + off) % N);
    any_o = |rot;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter sharing one FIFO write port between N producers.
// An owner keeps the port until its last word is written or it idles for TMO cycles.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int B   = 8,
  parameter int N   = 2,
  parameter int IW  = 1,
  parameter int TW  = 8,
  parameter int TMO = 255
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   last,
  input  logic [N*B-1:0] data,
  output logic [N-1:0]   ack,
  input  logic           fifo_full,
  output logic           fifo_wr,
  output logic [B-1:0]   fifo_w_data,
  output logic [IW-1:0]  grant_id,
  output logic           busy,
  output logic           timeout
);

  localparam bit          TMO_EN  = (TMO != 0);
  localparam logic [TW-1:0] TMO_LIM = TW'((TMO > 0) ? (TMO - 1) : 0);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_q, timeout_d;

  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          own_req;
  logic          own_last;
  logic          accept;

  fifo_wr_arbiter_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign own_req     = req[grant_q];
  assign own_last    = last[grant_q];
  // Data follows the current/last owner in both states so the bus stays stable.
  assign fifo_w_data = data[grant_q*B +: B];
  assign grant_id    = grant_q;
  assign busy        = (state_q == ST_GRANT);
  assign timeout     = timeout_q;
  // Full is checked here unconditionally: the FIFO's read+write path does not.
  assign accept      = (state_q == ST_GRANT) && own_req && !fifo_full;

  // State, owner, round-robin pointer and idle counter; reset drops any grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= IW'(N - 1);
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state: arbitrate in IDLE, stream/stall/time out in GRANT.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = 1'b0;
    ack       = '0;
    fifo_wr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d   = pick_idx;
          state_d   = ST_GRANT;
          tmo_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        ack[grant_q] = accept;
        fifo_wr      = accept;
        if (accept) begin
          tmo_cnt_d = '0;
          if (own_last) begin
            state_d  = ST_IDLE;
            rr_ptr_d = grant_q;
          end
        end else if (!own_req) begin
          // Packet gap; a full-FIFO stall with req held does not count.
          if (TMO_EN && tmo_cnt_q == TMO_LIM) begin
            state_d   = ST_IDLE;
            rr_ptr_d  = grant_q;
            timeout_d = 1'b1;
            tmo_cnt_d = '0;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter with a behavioural FIFO and producers.
module tb_fifo_wr_arbiter;
  localparam int B = 8, N = 2, IW = 1, TW = 8, TMO = 4, DEPTH = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req, last, ack;
  logic [N*B-1:0] data;
  logic           fifo_full, fifo_wr, busy, timeout;
  logic [B-1:0]   fifo_w_data;
  logic [IW-1:0]  grant_id;

  fifo_wr_arbiter #(.B(B), .N(N), .IW(IW), .TW(TW), .TMO(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .last(last), .data(data), .ack(ack),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_w_data(fifo_w_data),
    .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: who owns the port, rr position, gap length, pending timeout pulse.
  bit m_busy, m_tmo;
  int m_own, m_rr, m_cnt;

  // Producers hold whole packets as {last, data}; the FIFO is a plain queue.
  logic [8:0] ptx [N][$];
  logic [7:0] fq[$];
  logic [7:0] wlog[$];
  int n_tmo_seen, n_acc0;

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int k = 1; k <= N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_own = 0; m_rr = N - 1; m_cnt = 0; m_tmo = 0;
  endtask

  task automatic push_pkt(input int p, input int len, input logic [7:0] base);
    for (int j = 0; j < len; j++) ptx[p].push_back({(j == len - 1), 8'(base + j)});
  endtask

  // One clock: drive from producer queues, check at negedge, advance model at posedge.
  task automatic step(input bit rd, input logic [N-1:0] en);
    logic [N-1:0] eack;
    logic         ewr;
    logic [7:0]   wd;
    int           w;
    for (int i = 0; i < N; i++) begin
      req[i] = en[i] && (ptx[i].size() > 0);
      if (ptx[i].size() > 0) begin
        last[i] = ptx[i][0][8];
        data[i*B +: B] = ptx[i][0][7:0];
      end else begin
        last[i] = 1'($urandom);
        data[i*B +: B] = 8'($urandom);
      end
    end
    fifo_full = (fq.size() >= DEPTH);
    eack = '0;
    if (m_busy && req[m_own] && !fifo_full) eack[m_own] = 1'b1;
    ewr = |eack;
    wd  = data[m_own*B +: B];
    @(negedge clk);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("timeout", 32'(timeout), 32'(m_tmo));
    chk("ack", 32'(ack), 32'(eack));
    chk("fifo_wr", 32'(fifo_wr), 32'(ewr));
    if (m_busy) chk("grant_id", 32'(grant_id), 32'(m_own));
    if (ewr) chk("w_data", 32'(fifo_w_data), 32'(wd));
    if (fifo_wr) wlog.push_back(fifo_w_data);
    if (timeout) n_tmo_seen++;
    @(posedge clk);
    m_tmo = 0;
    if (!m_busy) begin
      w = pick(req, m_rr);
      if (w >= 0) begin m_busy = 1; m_own = w; m_cnt = 0; end
    end else if (ewr) begin
      if (last[m_own]) begin m_busy = 0; m_rr = m_own; end
      m_cnt = 0;
      void'(ptx[m_own].pop_front());
      if (m_own == 0) n_acc0++;
    end else if (!req[m_own]) begin
      if (TMO > 0 && m_cnt == TMO - 1) begin
        m_busy = 0; m_rr = m_own; m_tmo = 1; m_cnt = 0;
      end else m_cnt++;
    end
    if (rd && fq.size() > 0) void'(fq.pop_front());
    if (ewr) fq.push_back(wd);
    #1;
  endtask

  task automatic chk_log(input string tag, input logic [7:0] exp[$]);
    chk({tag, "_len"}, 32'(wlog.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < wlog.size(); i++) chk(tag, 32'(wlog[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [7:0] exp[$];
    logic [N-1:0] en;
    // 1. Reset with both requests raised
    reset_n = 1'b0; req = '1; last = '1; data = '0; fifo_full = 1'b0;
    n_tmo_seen = 0; n_acc0 = 0;
    @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_wr", 32'(fifo_wr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tmo", 32'(timeout), 0);
    chk("rst_gid", 32'(grant_id), 0);
    req = '0;
    #2 reset_n = 1'b1;
    model_reset();
    @(posedge clk); #1;

    // 2. Fairness: single-word packets from both, alternate with a bubble
    push_pkt(0, 1, 8'h3C); push_pkt(0, 1, 8'h3C);
    push_pkt(1, 1, 8'hC3); push_pkt(1, 1, 8'hC3);
    for (int c = 0; c < 8; c++) step(1'b0, '1);
    exp = '{8'h3C, 8'hC3, 8'h3C, 8'hC3};
    chk_log("fair", exp);

    // 3. Atomic packet while producer 1 keeps requesting
    fq.delete(); wlog.delete();
    push_pkt(0, 3, 8'hA1); push_pkt(1, 1, 8'hB0);
    for (int c = 0; c < 30 && (ptx[0].size() + ptx[1].size()) > 0; c++) step(1'b0, '1);
    step(1'b0, '1);
    exp = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
    chk_log("atomic", exp);

    // 4. Full FIFO: stall with req held, no timeout, resume after one read
    fq.delete(); wlog.delete(); n_tmo_seen = 0;
    push_pkt(0, 6, 8'h40);
    for (int c = 0; c < 10; c++) step(1'b0, 2'b01);
    chk("full_cnt", 32'(wlog.size()), 4);
    step(1'b1, 2'b01);
    step(1'b0, 2'b01);
    chk("full_resume", 32'(wlog.size()), 5);
    for (int c = 0; c < 20 && ptx[0].size() > 0; c++) step(1'b1, 2'b01);
    step(1'b1, 2'b01);
    exp = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    chk_log("full", exp);
    chk("full_no_tmo", 32'(n_tmo_seen), 0);

    // 5. Timeout: owner 1 sends one non-last word then goes quiet
    fq.delete(); wlog.delete(); n_tmo_seen = 0;
    ptx[1].push_back({1'b0, 8'h55});
    ptx[0].push_back({1'b1, 8'h77});
    for (int c = 0; c < 10; c++) step(1'b1, '1);
    chk("tmo_pulses", 32'(n_tmo_seen), 1);
    exp = '{8'h55, 8'h77};
    chk_log("tmo", exp);

    // 6. Reset between words 2 and 3 of a packet
    n_acc0 = 0;
    push_pkt(0, 4, 8'h61);
    for (int c = 0; c < 10 && n_acc0 < 2; c++) step(1'b1, 2'b01);
    req = 2'b01; last = 2'b00; data[B-1:0] = 8'h63; fifo_full = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_wr", 32'(fifo_wr), 0);
    chk("mid_rst_ack", 32'(ack), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    req = '0;
    for (int i = 0; i < N; i++) ptx[i].delete();
    model_reset();
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    ptx[0].push_back({1'b1, 8'h11});
    ptx[1].push_back({1'b1, 8'h22});
    step(1'b1, '1);
    step(1'b1, '1);
    chk("post_rst_gid", 32'(grant_id), 0);

    // Random traffic: packets of 1..4 words, random gaps and reads
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (ptx[i].size() == 0 && ($urandom % 4) == 0)
          push_pkt(i, int'($urandom_range(1, 4)), 8'($urandom));
        en[i] = (($urandom % 4) != 0);
      end
      step(1'($urandom), en);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
